brdg_retry_replay: RTL and testbench
====================================

BRDG_RETRY_REPLAY -- requirements
Module: brdg_retry_replay

Interface
REQ-001 SHALL have parameter TAGW, default `TAGW, meaning AFU tag width.
REQ-002 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port cap_valid, input, 1, meaning an issued command is captured this cycle.
REQ-005 SHALL have port cap_tag, input, TAGW, meaning the tag of the captured command.
REQ-006 SHALL have port cap_opcode, input, 8, meaning the opcode of the captured command.
REQ-007 SHALL have port cap_ea, input, 64, meaning the base effective address of the captured command.
REQ-008 SHALL have port cap_dl, input, 2, meaning the data length of the captured command.
REQ-009 SHALL have port cap_partial, input, 1, meaning the captured command is partial.
REQ-010 SHALL have port done_valid, input, 1, meaning the final good response arrived for done_tag.
REQ-011 SHALL have port done_tag, input, TAGW, meaning the tag being retired.
REQ-012 SHALL have port rty_rdy, output, 1, meaning the block can accept a retry request.
REQ-013 SHALL have port rty_valid, input, 1, meaning a retry request is presented; it is asserted only while rty_rdy=1.
REQ-014 SHALL have port rty_pos, input, 2, meaning the 64B segment index of the retry.
REQ-015 SHALL have port rty_tag, input, TAGW, meaning the tag to replay.
REQ-016 SHALL have port rpl_valid, output, 1, meaning a replay command is valid.
REQ-017 SHALL have port rpl_rdy, input, 1, meaning downstream accepts the replay command.
REQ-018 SHALL have ports rpl_tag (TAGW), rpl_opcode (8), rpl_ea (64) and rpl_dl (2), all outputs, carrying the replay command fields.
REQ-019 SHALL have port rpl_err, output, 1, meaning a one-cycle pulse when a retry names an unrecorded tag.
REQ-020 SHALL have port rpl_cnt, output, 16, meaning the count of accepted replays.

Function
REQ-021 SHALL store {opcode, ea, dl, partial} per tag in a simple dual-port RAM, 2^TAGW x 75 bits, written at cap_tag on cap_valid, with 1-cycle read latency.
REQ-022 SHALL keep a per-tag valid bit array: set on cap_valid, cleared on done_valid; cap_valid wins when both hit the same tag in one cycle.
REQ-023 SHALL implement FSM states IDLE, READ, WAIT, DRIVE with the following transitions:
  - IDLE -> READ on rty_valid; rty_tag, rty_pos and valid[rty_tag] are latched in that cycle.
  - READ -> WAIT unconditionally; the RAM address is presented in READ.
  - WAIT -> DRIVE if the latched valid bit is 1.
  - WAIT -> IDLE if the latched valid bit is 0, with rpl_err=1 for exactly that cycle.
  - DRIVE -> IDLE when rpl_rdy=1.
REQ-024 SHALL assert rty_rdy = (state==IDLE); a request is accepted in the cycle where rty_valid=1.
REQ-025 SHALL, in DRIVE, assert rpl_valid=1 and hold all rpl_* fields stable until rpl_rdy=1; transfer occurs on rpl_valid && rpl_rdy.
REQ-026 SHALL form replay fields for a partial entry as rpl_ea = base_ea + {rty_pos, 6'b0} and rpl_dl = 2'b01 (64B).
REQ-027 SHALL form replay fields for a non-partial entry as rpl_ea = base_ea and rpl_dl = stored dl, with rty_pos ignored.
REQ-028 SHALL set rpl_opcode to the stored opcode and rpl_tag to the latched tag.
REQ-029 SHALL compute the EA addition modulo 2^64 (wraps, no carry out).
REQ-030 SHALL make minimum request-to-rpl_valid latency 3 cycles: accept in cycle N gives rpl_valid in cycle N+3.
REQ-031 SHALL make minimum back-to-back throughput one replay per 4 cycles.
REQ-032 SHALL let a RAM write to the tag currently being read take effect for the read (write-first) only if it occurs in the READ cycle; writes after READ do not alter the held replay.
REQ-033 SHALL increment rpl_cnt by 1 per transfer and saturate at 16'hFFFF.
REQ-034 SHALL make no change to the valid array as a result of a replay.

Reset
REQ-035 SHALL, while rst_n=0, force state=IDLE, rty_rdy=1 after reset release, and rpl_valid=0, rpl_err=0, rpl_cnt=0, rpl_* fields=0, latched tag/pos=0, and all valid bits=0.
REQ-036 SHALL treat reset asserted mid-DRIVE as dropping the replay immediately; the RAM contents are not required to reset.

Verification
REQ-037 SHALL cover: capture tag 5 (opcode 8'h10, ea 64'h1000, dl 2'b10, non-partial), then retry tag 5 pos 3 -> rpl_valid 3 cycles later with ea 64'h1000, dl 2'b10, opcode 8'h10, rpl_cnt=1.
REQ-038 SHALL cover: capture tag 9 partial with ea 64'h2000, then retry pos 2 -> rpl_ea 64'h2080, rpl_dl 2'b01.
REQ-039 SHALL cover: retry tag 3 never captured -> no rpl_valid, rpl_err pulses once 2 cycles after accept, rty_rdy returns to 1 the next cycle.
REQ-040 SHALL cover: rpl_rdy held 0 for 10 cycles in DRIVE -> fields stable, rty_rdy=0 throughout; rpl_rdy=1 -> IDLE next cycle.
REQ-041 SHALL cover: done_valid tag 5, then retry tag 5 -> rpl_err; same-cycle cap_valid and done_valid on tag 7, then retry tag 7 -> replay issued.
REQ-042 SHALL cover: ea 64'hFFFF_FFFF_FFFF_FFC0 partial, pos 1 -> rpl_ea 64'h0; rpl_cnt preloaded to saturation stays at 16'hFFFF.

Source files
------------

// File: rtl/brdg_retry_replay.sv
// Retry replay engine for the bridge: records issued commands per tag and
// re-issues a command (or one 64B segment of a partial one) on a retry request.
//
// state | meaning
// IDLE  | ready for a retry request (rty_rdy=1)
// READ  | RAM address presented for the latched tag
// WAIT  | RAM data available; replay fields formed, or error flagged
// DRIVE | replay command held on rpl_* until rpl_rdy

`ifndef TAGW
`define TAGW 4
`endif

module brdg_retry_replay #(
  parameter int TAGW = `TAGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap_valid,
  input  logic [TAGW-1:0] cap_tag,
  input  logic [7:0]      cap_opcode,
  input  logic [63:0]     cap_ea,
  input  logic [1:0]      cap_dl,
  input  logic            cap_partial,
  input  logic            done_valid,
  input  logic [TAGW-1:0] done_tag,
  output logic            rty_rdy,
  input  logic            rty_valid,
  input  logic [1:0]      rty_pos,
  input  logic [TAGW-1:0] rty_tag,
  output logic            rpl_valid,
  input  logic            rpl_rdy,
  output logic [TAGW-1:0] rpl_tag,
  output logic [7:0]      rpl_opcode,
  output logic [63:0]     rpl_ea,
  output logic [1:0]      rpl_dl,
  output logic            rpl_err,
  output logic [15:0]     rpl_cnt
);

  localparam int DEPTH = 1 << TAGW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRIVE = 2'd3
  } state_e;

  // Entry layout: {opcode[74:67], ea[66:3], dl[2:1], partial[0]}
  logic [74:0]      mem [DEPTH];
  logic [74:0]      wr_data;
  logic [74:0]      rd_data_q, rd_data_d;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAGW-1:0]  lat_tag_q, lat_tag_d;
  logic [1:0]       lat_pos_q, lat_pos_d;
  logic             lat_vld_q, lat_vld_d;
  logic             rty_rdy_q, rty_rdy_d;
  logic             rpl_valid_q, rpl_valid_d;
  logic [TAGW-1:0]  rpl_tag_q, rpl_tag_d;
  logic [7:0]       rpl_opcode_q, rpl_opcode_d;
  logic [63:0]      rpl_ea_q, rpl_ea_d;
  logic [1:0]       rpl_dl_q, rpl_dl_d;
  logic             rpl_err_q, rpl_err_d;
  logic [15:0]      rpl_cnt_q, rpl_cnt_d;

  logic [7:0]       rd_opcode;
  logic [63:0]      rd_ea;
  logic [1:0]       rd_dl;
  logic             rd_partial;

  assign wr_data    = {cap_opcode, cap_ea, cap_dl, cap_partial};
  assign rd_opcode  = rd_data_q[74:67];
  assign rd_ea      = rd_data_q[66:3];
  assign rd_dl      = rd_data_q[2:1];
  assign rd_partial = rd_data_q[0];

  // RAM read port: sampled only in READ; a same-cycle capture to the same tag bypasses the array
  always_comb begin
    rd_data_d = rd_data_q;
    if (state_q == ST_READ) begin
      if (cap_valid && (cap_tag == lat_tag_q)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[lat_tag_q];
      end
    end
  end

  // Command store and read register; contents are not reset
  always_ff @(posedge clk) begin
    if (cap_valid) begin
      mem[cap_tag] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  // Next-state, tag valid tracking and replay field formation
  always_comb begin
    state_d      = state_q;
    lat_tag_d    = lat_tag_q;
    lat_pos_d    = lat_pos_q;
    lat_vld_d    = lat_vld_q;
    rty_rdy_d    = rty_rdy_q;
    rpl_valid_d  = rpl_valid_q;
    rpl_tag_d    = rpl_tag_q;
    rpl_opcode_d = rpl_opcode_q;
    rpl_ea_d     = rpl_ea_q;
    rpl_dl_d     = rpl_dl_q;
    rpl_err_d    = 1'b0;
    rpl_cnt_d    = rpl_cnt_q;

    // capture wins over retire on the same tag
    valid_d = valid_q;
    if (done_valid) valid_d[done_tag] = 1'b0;
    if (cap_valid)  valid_d[cap_tag]  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rty_valid) begin
          state_d   = ST_READ;
          lat_tag_d = rty_tag;
          lat_pos_d = rty_pos;
          lat_vld_d = valid_q[rty_tag];
          rty_rdy_d = 1'b0;
        end
      end
      ST_READ: begin
        state_d   = ST_WAIT;
        // error is registered so it is visible exactly during WAIT
        rpl_err_d = ~lat_vld_q;
      end
      ST_WAIT: begin
        if (lat_vld_q) begin
          state_d      = ST_DRIVE;
          rpl_valid_d  = 1'b1;
          rpl_tag_d    = lat_tag_q;
          rpl_opcode_d = rd_opcode;
          if (rd_partial) begin
            rpl_ea_d = rd_ea + 64'({lat_pos_q, 6'b000000});
            rpl_dl_d = 2'b01;
          end else begin
            rpl_ea_d = rd_ea;
            rpl_dl_d = rd_dl;
          end
        end else begin
          state_d   = ST_IDLE;
          rty_rdy_d = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (rpl_rdy) begin
          state_d     = ST_IDLE;
          rpl_valid_d = 1'b0;
          rty_rdy_d   = 1'b1;
          if (rpl_cnt_q != 16'hFFFF) begin
            rpl_cnt_d = rpl_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rty_rdy_d = 1'b1;
      end
    endcase
  end

  // FSM state, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      lat_tag_q    <= '0;
      lat_pos_q    <= '0;
      lat_vld_q    <= 1'b0;
      rty_rdy_q    <= 1'b1;
      rpl_valid_q  <= 1'b0;
      rpl_tag_q    <= '0;
      rpl_opcode_q <= '0;
      rpl_ea_q     <= '0;
      rpl_dl_q     <= '0;
      rpl_err_q    <= 1'b0;
      rpl_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      lat_tag_q    <= lat_tag_d;
      lat_pos_q    <= lat_pos_d;
      lat_vld_q    <= lat_vld_d;
      rty_rdy_q    <= rty_rdy_d;
      rpl_valid_q  <= rpl_valid_d;
      rpl_tag_q    <= rpl_tag_d;
      rpl_opcode_q <= rpl_opcode_d;
      rpl_ea_q     <= rpl_ea_d;
      rpl_dl_q     <= rpl_dl_d;
      rpl_err_q    <= rpl_err_d;
      rpl_cnt_q    <= rpl_cnt_d;
    end
  end

  assign rty_rdy    = rty_rdy_q;
  assign rpl_valid  = rpl_valid_q;
  assign rpl_tag    = rpl_tag_q;
  assign rpl_opcode = rpl_opcode_q;
  assign rpl_ea     = rpl_ea_q;
  assign rpl_dl     = rpl_dl_q;
  assign rpl_err    = rpl_err_q;
  assign rpl_cnt    = rpl_cnt_q;

endmodule

// File: tb/tb_brdg_retry_replay.sv
// Bench for brdg_retry_replay: directed scenarios followed by randomized
// capture/retire traffic with retries, checked against a per-tag command table.

module tb_brdg_retry_replay;

  localparam int TW = 4;
  localparam int NT = 1 << TW;

  logic          clk;
  logic          rst_n;
  logic          cap_valid;
  logic [TW-1:0] cap_tag;
  logic [7:0]    cap_opcode;
  logic [63:0]   cap_ea;
  logic [1:0]    cap_dl;
  logic          cap_partial;
  logic          done_valid;
  logic [TW-1:0] done_tag;
  logic          rty_rdy;
  logic          rty_valid;
  logic [1:0]    rty_pos;
  logic [TW-1:0] rty_tag;
  logic          rpl_valid;
  logic          rpl_rdy;
  logic [TW-1:0] rpl_tag;
  logic [7:0]    rpl_opcode;
  logic [63:0]   rpl_ea;
  logic [1:0]    rpl_dl;
  logic          rpl_err;
  logic [15:0]   rpl_cnt;

  brdg_retry_replay dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_valid  (cap_valid),
    .cap_tag    (cap_tag),
    .cap_opcode (cap_opcode),
    .cap_ea     (cap_ea),
    .cap_dl     (cap_dl),
    .cap_partial(cap_partial),
    .done_valid (done_valid),
    .done_tag   (done_tag),
    .rty_rdy    (rty_rdy),
    .rty_valid  (rty_valid),
    .rty_pos    (rty_pos),
    .rty_tag    (rty_tag),
    .rpl_valid  (rpl_valid),
    .rpl_rdy    (rpl_rdy),
    .rpl_tag    (rpl_tag),
    .rpl_opcode (rpl_opcode),
    .rpl_ea     (rpl_ea),
    .rpl_dl     (rpl_dl),
    .rpl_err    (rpl_err),
    .rpl_cnt    (rpl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  bit          bg_en = 1'b0;

  // reference table: what was last captured per tag and whether it is outstanding
  logic [NT-1:0] mv;
  logic [7:0]    m_op [NT];
  logic [63:0]   m_ea [NT];
  logic [1:0]    m_dl [NT];
  logic          m_pt [NT];
  logic [15:0]   mcnt = 16'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference table update from the bench's own capture/retire stimulus
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= '0;
    end else begin
      if (done_valid) mv[done_tag] <= 1'b0;
      if (cap_valid) begin
        mv[cap_tag]   <= 1'b1;
        m_op[cap_tag] <= cap_opcode;
        m_ea[cap_tag] <= cap_ea;
        m_dl[cap_tag] <= cap_dl;
        m_pt[cap_tag] <= cap_partial;
      end
    end
  end

  // background capture/retire traffic for the random phase
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bg_en) begin
        cap_valid   = ($urandom_range(0, 1) == 1);
        cap_tag     = TW'($urandom_range(0, NT - 1));
        cap_opcode  = 8'($urandom);
        cap_ea      = {$urandom, $urandom};
        cap_dl      = 2'($urandom_range(0, 3));
        cap_partial = ($urandom_range(0, 1) == 1);
        done_valid  = ($urandom_range(0, 3) == 0);
        done_tag    = TW'($urandom_range(0, NT - 1));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cap(input logic [TW-1:0] t, input logic [7:0] op, input logic [63:0] ea,
                     input logic [1:0] dl, input logic p);
    cap_valid = 1'b1; cap_tag = t; cap_opcode = op; cap_ea = ea; cap_dl = dl; cap_partial = p;
    step();
    cap_valid = 1'b0;
  endtask

  task automatic retire(input logic [TW-1:0] t);
    done_valid = 1'b1; done_tag = t;
    step();
    done_valid = 1'b0;
  endtask

  // one retry from acceptance to completion; abort asserts reset while the replay is held
  task automatic retry(input logic [TW-1:0] t, input logic [1:0] p, input int hold, input bit abort);
    bit          ev;
    logic [7:0]  eo;
    logic [63:0] ea;
    logic [1:0]  edl;
    chk("rty_rdy_idle", 64'(rty_rdy), 64'd1);
    ev = mv[t];
    rty_valid = 1'b1; rty_tag = t; rty_pos = p; rpl_rdy = 1'b0;
    step();
    rty_valid = 1'b0;
    chk("rty_rdy_read", 64'(rty_rdy), 64'd0);
    chk("rpl_valid_read", 64'(rpl_valid), 64'd0);
    chk("rpl_err_read", 64'(rpl_err), 64'd0);
    step();
    // table now holds every capture up to and including the READ cycle
    eo = m_op[t];
    if (m_pt[t]) begin
      ea  = m_ea[t] + 64'({p, 6'b000000});
      edl = 2'b01;
    end else begin
      ea  = m_ea[t];
      edl = m_dl[t];
    end
    chk("rpl_err_wait", 64'(rpl_err), 64'(!ev));
    chk("rpl_valid_wait", 64'(rpl_valid), 64'd0);
    chk("rty_rdy_wait", 64'(rty_rdy), 64'd0);
    step();
    if (!ev) begin
      chk("rpl_valid_noent", 64'(rpl_valid), 64'd0);
      chk("rty_rdy_after_err", 64'(rty_rdy), 64'd1);
      chk("rpl_err_once", 64'(rpl_err), 64'd0);
      return;
    end
    chk("rpl_valid_lat3", 64'(rpl_valid), 64'd1);
    chk("rpl_tag", 64'(rpl_tag), 64'(t));
    chk("rpl_opcode", 64'(rpl_opcode), 64'(eo));
    chk("rpl_ea", rpl_ea, ea);
    chk("rpl_dl", 64'(rpl_dl), 64'(edl));
    chk("rty_rdy_drive", 64'(rty_rdy), 64'd0);
    if (abort) begin
      rst_n = 1'b0;
      #1;
      mcnt = 16'd0;
      chk("rst_drop_valid", 64'(rpl_valid), 64'd0);
      chk("rst_rty_rdy", 64'(rty_rdy), 64'd1);
      chk("rst_rpl_ea", rpl_ea, 64'd0);
      chk("rst_rpl_cnt", 64'(rpl_cnt), 64'd0);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 64'(rpl_valid), 64'd1);
      chk("hold_ea", rpl_ea, ea);
      chk("hold_op", 64'(rpl_opcode), 64'(eo));
      chk("hold_dl", 64'(rpl_dl), 64'(edl));
      chk("hold_tag", 64'(rpl_tag), 64'(t));
      chk("hold_rty_rdy", 64'(rty_rdy), 64'd0);
    end
    rpl_rdy = 1'b1;
    step();
    rpl_rdy = 1'b0;
    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    chk("post_xfer_valid", 64'(rpl_valid), 64'd0);
    chk("post_xfer_rty_rdy", 64'(rty_rdy), 64'd1);
    chk("rpl_cnt", 64'(rpl_cnt), 64'(mcnt));
  endtask

  initial begin
    rst_n = 1'b0;
    cap_valid = 1'b0; cap_tag = '0; cap_opcode = '0; cap_ea = '0; cap_dl = '0; cap_partial = 1'b0;
    done_valid = 1'b0; done_tag = '0;
    rty_valid = 1'b0; rty_pos = '0; rty_tag = '0; rpl_rdy = 1'b0;
    repeat (3) step();
    chk("reset_rpl_valid", 64'(rpl_valid), 64'd0);
    chk("reset_rpl_err", 64'(rpl_err), 64'd0);
    chk("reset_rpl_cnt", 64'(rpl_cnt), 64'd0);
    chk("reset_rpl_ea", rpl_ea, 64'd0);
    chk("reset_rpl_fields", {52'd0, rpl_tag, rpl_opcode}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("reset_rty_rdy", 64'(rty_rdy), 64'd1);

    // non-partial replay ignores pos
    cap(4'd5, 8'h10, 64'h1000, 2'b10, 1'b0);
    retry(4'd5, 2'd3, 0, 1'b0);
    // partial replay selects a 64B segment
    cap(4'd9, 8'h20, 64'h2000, 2'b11, 1'b1);
    retry(4'd9, 2'd2, 0, 1'b0);
    // never captured
    retry(4'd3, 2'd0, 0, 1'b0);
    // back-pressure for 10 cycles
    cap(4'd12, 8'h33, 64'hDEAD_BEEF_0000_0040, 2'b00, 1'b0);
    retry(4'd12, 2'd1, 10, 1'b0);
    // retired tag, then capture winning over retire
    retire(4'd5);
    retry(4'd5, 2'd0, 0, 1'b0);
    cap_valid = 1'b1; cap_tag = 4'd7; cap_opcode = 8'h77; cap_ea = 64'h7700; cap_dl = 2'b01;
    cap_partial = 1'b0; done_valid = 1'b1; done_tag = 4'd7;
    step();
    cap_valid = 1'b0; done_valid = 1'b0;
    retry(4'd7, 2'd2, 0, 1'b0);
    // address wrap
    cap(4'd14, 8'h44, 64'hFFFF_FFFF_FFFF_FFC0, 2'b11, 1'b1);
    retry(4'd14, 2'd1, 1, 1'b0);
    // replay does not consume the entry
    retry(4'd14, 2'd3, 0, 1'b0);
    // counter saturation
    force dut.rpl_cnt_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    @(negedge clk);
    release dut.rpl_cnt_q;
    step();
    retry(4'd9, 2'd1, 0, 1'b0);
    retry(4'd9, 2'd0, 0, 1'b0);
    retry(4'd9, 2'd3, 2, 1'b0);
    // reset while driving a replay
    retry(4'd12, 2'd0, 0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    step();
    retry(4'd12, 2'd0, 0, 1'b0);

    // randomized capture/retire traffic with overlapping retries
    bg_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      retry(TW'($urandom_range(0, NT - 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 2) == 0) step();
    end
    bg_en = 1'b0;
    step();
    cap_valid = 1'b0; done_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
